// File: rtl/demodulator.sv
// On-off-keyed carrier demodulator: recovers the data bit from a gated square-wave carrier
// by qualifying edge spacing against the modulator's half-period setting, and flags early edges.
module demodulator #(
   parameter int CTR_WIDTH   = 16,
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_EDGES  = 4
) (
   input  logic                 clk,
   input  logic                 n_reset,
   input  logic                 in,
   input  logic [CTR_WIDTH-1:0] cycles_per_half_period,
   output logic                 data_out,
   output logic                 glitch,
   output logic [1:0]           state
);

   localparam int GW = CTR_WIDTH + 1;
   localparam int CW = $clog2(LOCK_EDGES + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s, p, edge_det;
   logic [GW-1:0]          g, n_ext, lo, hi, hi_p1;
   logic                   early, late, timeout, degenerate;
   state_t                 st;
   logic [CW-1:0]          cnt;

   assign s        = sync_q[SYNC_STAGES-1];
   assign edge_det = s ^ p;

   // Window math is one bit wider than N so hi = 1.5*N cannot overflow.
   assign n_ext      = {1'b0, cycles_per_half_period};
   assign lo         = n_ext >> 1;
   assign hi         = n_ext + lo;
   assign hi_p1      = hi + 1'b1;
   assign early      = g < lo;
   assign late       = g > hi;
   assign timeout    = !edge_det && (g == hi_p1);
   assign degenerate = cycles_per_half_period < CTR_WIDTH'(2);

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         sync_q <= '0;
         p      <= 1'b0;
         g      <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], in};
         p      <= s;
         if (edge_det)
            g <= '0;
         else if (g != '1)
            g <= g + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         st       <= IDLE;
         cnt      <= '0;
         data_out <= 1'b0;
         glitch   <= 1'b0;
      end else begin
         glitch <= 1'b0;
         if (degenerate) begin
            st       <= IDLE;
            cnt      <= '0;
            data_out <= 1'b0;
         end else begin
            case (st)
               IDLE: begin
                  // First edge has no reference, so it cannot be judged early.
                  if (edge_det) begin
                     st  <= ACQUIRE;
                     cnt <= CW'(1);
                  end
               end
               ACQUIRE, LOCKED: begin
                  if (edge_det) begin
                     if (early) begin
                        st       <= IDLE;
                        cnt      <= '0;
                        data_out <= 1'b0;
                        glitch   <= 1'b1;
                     end else if (late) begin
                        st       <= ACQUIRE;
                        cnt      <= CW'(1);
                        data_out <= 1'b0;
                     end else if (st == ACQUIRE) begin
                        cnt <= cnt + 1'b1;
                        if (cnt + 1'b1 == CW'(LOCK_EDGES)) begin
                           st       <= LOCKED;
                           data_out <= 1'b1;
                        end
                     end
                  end else if (timeout) begin
                     st       <= IDLE;
                     cnt      <= '0;
                     data_out <= 1'b0;
                  end
               end
               default: begin
                  st       <= IDLE;
                  data_out <= 1'b0;
               end
            endcase
         end
      end
   end

   assign state = st;

endmodule

// File: tb/tb_demodulator.sv
// Directed bench for demodulator at N=9 (T=10, window 4..13), LOCK_EDGES=4, SYNC_STAGES=2.
module tb_demodulator;

   logic        clk = 1'b0;
   logic        n_reset;
   logic        in;
   logic [15:0] cycles_per_half_period;
   logic        data_out, glitch;
   logic [1:0]  state;

   int n_tests = 0;
   int n_fail  = 0;

   demodulator #(.CTR_WIDTH(16), .SYNC_STAGES(2), .LOCK_EDGES(4)) dut (
      .clk                    (clk),
      .n_reset                (n_reset),
      .in                     (in),
      .cycles_per_half_period (cycles_per_half_period),
      .data_out               (data_out),
      .glitch                 (glitch),
      .state                  (state)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Enters from any state, waits out any timeout, then locks; returns just after the
   // clock on which the 4th edge was acted on (raw toggle was 3 clocks earlier).
   task automatic lock_up();
      step(20);
      for (int e = 0; e < 4; e++) begin
         if (e > 0) step(7);
         in = ~in;
         step(3);
      end
   endtask

   // Raw toggle S clocks after the previous one; returns just after its detection clock.
   task automatic spaced_edge(input int s);
      step(s - 3);
      in = ~in;
      step(3);
   endtask

   task automatic test_reset();
      n_reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i % 3 == 0) in = ~in;
         step(1);
         n_tests++;
         if ({state, data_out, glitch} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_hold cyc %0d: state=%0d data_out=%b glitch=%b, want 0/0/0",
                     i, state, data_out, glitch);
         end
      end
   endtask

   task automatic test_acquire();
      in = 1'b0;
      n_reset = 1'b1;
      step(20);
      n_tests++;
      if (state !== 2'd0) begin
         n_fail++;
         $display("FAIL acquire_start: state=%0d, want 0", state);
      end
      for (int e = 1; e <= 4; e++) begin
         in = ~in;
         step(2);
         n_tests++;
         if (state !== ((e == 1) ? 2'd0 : 2'd1) || data_out !== 1'b0) begin
            n_fail++;
            $display("FAIL acquire_pre edge %0d: state=%0d data_out=%b, want %0d/0",
                     e, state, data_out, (e == 1) ? 0 : 1);
         end
         step(1);
         n_tests++;
         if (state !== ((e < 4) ? 2'd1 : 2'd2) || data_out !== (e == 4) || glitch !== 1'b0) begin
            n_fail++;
            $display("FAIL acquire_post edge %0d: state=%0d data_out=%b glitch=%b, want %0d/%0d/0",
                     e, state, data_out, glitch, (e < 4) ? 1 : 2, (e == 4) ? 1 : 0);
         end
         if (e < 4) step(7);
      end
   endtask

   task automatic test_carrier_loss();
      lock_up();
      for (int k = 1; k <= 15; k++) begin
         step(1);
         n_tests++;
         if (data_out !== (k < 15)) begin
            n_fail++;
            $display("FAIL carrier_loss clk %0d: data_out=%b, want %0d", k, data_out, (k < 15) ? 1 : 0);
         end
      end
      n_tests++;
      if (state !== 2'd0 || glitch !== 1'b0) begin
         n_fail++;
         $display("FAIL carrier_loss_state: state=%0d glitch=%b, want 0/0", state, glitch);
      end
   endtask

   task automatic test_glitch();
      lock_up();
      in = ~in;
      step(2);
      n_tests++;
      if (state !== 2'd2 || glitch !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch_pre: state=%0d glitch=%b, want 2/0", state, glitch);
      end
      step(1);
      n_tests++;
      if ({state, data_out, glitch} !== 4'b0001) begin
         n_fail++;
         $display("FAIL glitch_hit: state=%0d data_out=%b glitch=%b, want 0/0/1", state, data_out, glitch);
      end
      step(1);
      n_tests++;
      if ({state, data_out, glitch} !== 4'b0000) begin
         n_fail++;
         $display("FAIL glitch_one_cycle: state=%0d data_out=%b glitch=%b, want 0/0/0",
                  state, data_out, glitch);
      end
   endtask

   task automatic test_boundaries();
      lock_up();
      spaced_edge(5);
      n_tests++;
      if ({state, data_out, glitch} !== 4'b1010) begin
         n_fail++;
         $display("FAIL spacing5: state=%0d data_out=%b glitch=%b, want 2/1/0", state, data_out, glitch);
      end
      spaced_edge(14);
      n_tests++;
      if ({state, data_out, glitch} !== 4'b1010) begin
         n_fail++;
         $display("FAIL spacing14: state=%0d data_out=%b glitch=%b, want 2/1/0", state, data_out, glitch);
      end
      spaced_edge(4);
      n_tests++;
      if ({state, data_out, glitch} !== 4'b0001) begin
         n_fail++;
         $display("FAIL spacing4: state=%0d data_out=%b glitch=%b, want 0/0/1", state, data_out, glitch);
      end
      lock_up();
      spaced_edge(15);
      n_tests++;
      if ({state, data_out, glitch} !== 4'b0100) begin
         n_fail++;
         $display("FAIL spacing15: state=%0d data_out=%b glitch=%b, want 1/0/0", state, data_out, glitch);
      end
   endtask

   task automatic test_reset_mid();
      lock_up();
      n_tests++;
      if (state !== 2'd2) begin
         n_fail++;
         $display("FAIL reset_mid_locked: state=%0d, want 2", state);
      end
      n_reset = 1'b0;
      step(1);
      n_reset = 1'b1;
      n_tests++;
      if ({state, data_out, glitch} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_mid: state=%0d data_out=%b glitch=%b, want 0/0/0", state, data_out, glitch);
      end
   endtask

   task automatic test_degenerate();
      cycles_per_half_period = 16'd1;
      for (int i = 0; i < 30; i++) begin
         if (i % 3 == 0) in = ~in;
         step(1);
         n_tests++;
         if ({state, data_out, glitch} !== 4'b0000) begin
            n_fail++;
            $display("FAIL degenerate cyc %0d: state=%0d data_out=%b glitch=%b, want 0/0/0",
                     i, state, data_out, glitch);
         end
      end
   endtask

   initial begin
      n_reset = 1'b0;
      in = 1'b0;
      cycles_per_half_period = 16'd9;
      test_reset();
      test_acquire();
      test_carrier_loss();
      test_glitch();
      test_boundaries();
      test_reset_mid();
      test_degenerate();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
